axil_master: RTL



---
 rtl/axil_master.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AW/W/B or AR/R transaction, one response out.
// Optional AXIL_MASTER_ERRCNT_EN adds a saturating count of non-OKAY responses on err_count.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// WADDR   | AW and W offered, each dropped on its own handshake
// WRESP   | bready high, waiting for B
// RADDR   | AR offered
// RDATA   | rready high, waiting for R
// RSP     | response held on rsp_* until accepted

module axil_master #(
    parameter int axil_addr_width = 32,
    parameter int axil_data_width = 32
) (
    input  logic                         m_axi_aclk,
    input  logic                         m_axi_areset,

    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [axil_addr_width-1:0]   cmd_addr,
    input  logic [axil_data_width-1:0]   cmd_wdata,
    input  logic [axil_data_width/8-1:0] cmd_wstrb,

    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         rsp_write,
    output logic [axil_data_width-1:0]   rsp_rdata,
    output logic [1:0]                   rsp_resp,

`ifdef AXIL_MASTER_ERRCNT_EN
    output logic [15:0]                  err_count,
`endif

    output logic                         m_axi_awvalid,
    input  logic                         m_axi_awready,
    output logic [axil_addr_width-1:0]   m_axi_awaddr,
    output logic [2:0]                   m_axi_awprot,

    output logic                         m_axi_wvalid,
    input  logic                         m_axi_wready,
    output logic [axil_data_width-1:0]   m_axi_wdata,
    output logic [axil_data_width/8-1:0] m_axi_wstrb,

    input  logic                         m_axi_bvalid,
    output logic                         m_axi_bready,
    input  logic [1:0]                   m_axi_bresp,

    output logic                         m_axi_arvalid,
    input  logic                         m_axi_arready,
    output logic [axil_addr_width-1:0]   m_axi_araddr,
    output logic [2:0]                   m_axi_arprot,

    input  logic                         m_axi_rvalid,
    output logic                         m_axi_rready,
    input  logic [axil_data_width-1:0]   m_axi_rdata,
    input  logic [1:0]                   m_axi_rresp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_RSP
    } state_t;

    state_t state, state_nx;

    logic                         live;
    logic                         aw_done;
    logic                         w_done;
    logic                         write_q;
    logic [axil_addr_width-1:0]   addr_q;
    logic [axil_data_width-1:0]   wdata_q;
    logic [axil_data_width/8-1:0] wstrb_q;
    logic [axil_data_width-1:0]   rdata_q;
    logic [1:0]                   resp_q;

    logic cmd_fire, rsp_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire;

    // Every handshake output decodes from registered state only; live keeps
    // cmd_ready low until the first clock after reset release.
    assign cmd_ready     = live && (state == S_IDLE);
    assign m_axi_awvalid = (state == S_WADDR) && !aw_done;
    assign m_axi_wvalid  = (state == S_WADDR) && !w_done;
    assign m_axi_bready  = (state == S_WRESP);
    assign m_axi_arvalid = (state == S_RADDR);
    assign m_axi_rready  = (state == S_RDATA);
    assign rsp_valid     = (state == S_RSP);

    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;

    assign rsp_write     = write_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign rsp_fire = rsp_valid && rsp_ready;
    assign aw_fire  = m_axi_awvalid && m_axi_awready;
    assign w_fire   = m_axi_wvalid && m_axi_wready;
    assign b_fire   = m_axi_bvalid && m_axi_bready;
    assign ar_fire  = m_axi_arvalid && m_axi_arready;
    assign r_fire   = m_axi_rvalid && m_axi_rready;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (cmd_fire) state_nx = cmd_write ? S_WADDR : S_RADDR;
            S_WADDR: if ((aw_done || aw_fire) && (w_done || w_fire)) state_nx = S_WRESP;
            S_WRESP: if (b_fire) state_nx = S_RSP;
            S_RADDR: if (ar_fire) state_nx = S_RDATA;
            S_RDATA: if (r_fire) state_nx = S_RSP;
            S_RSP:   if (rsp_fire) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            state   <= S_IDLE;
            live    <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            resp_q  <= 2'b00;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
            if (cmd_fire) begin
                write_q <= cmd_write;
                addr_q  <= cmd_addr;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (cmd_write) begin
                    wdata_q <= cmd_wdata;
                    wstrb_q <= cmd_wstrb;
                end
            end
            if (aw_fire) aw_done <= 1'b1;
            if (w_fire)  w_done  <= 1'b1;
            if (b_fire) begin
                resp_q  <= m_axi_bresp;
                rdata_q <= '0;
            end
            if (r_fire) begin
                resp_q  <= m_axi_rresp;
                rdata_q <= m_axi_rdata;
            end
        end
    end

`ifdef AXIL_MASTER_ERRCNT_EN
    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            err_count <= 16'h0000;
        end else if (((b_fire && m_axi_bresp != 2'b00) || (r_fire && m_axi_rresp != 2'b00))
                     && err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule
